// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared types and helpers for the priority-queue host adapter
package pq_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pq_state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REPL = 2'd3
  } pq_op_e;

  // Mirror counter must hold 0..QUEUE_SIZE inclusive.
  function automatic int count_width(input int queue_size);
    return $clog2(queue_size) + 1;
  endfunction

endpackage

// File: rtl/pq_res_reg.sv
// rtl/pq_res_reg.sv - one-entry valid/ready register holding the popped head
module pq_res_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Load wins over a same-cycle handoff so back-to-back pops stream.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/pq_host_adapter.sv
// rtl/pq_host_adapter.sv - push/pop/result handshake adapter for the max-priority queue
module pq_host_adapter
  import pq_pkg::*;
#(
  parameter int ENQ_ENA    = 0,
  parameter int QUEUE_SIZE = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop_valid,
  output logic                  o_pop_ready,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [DATA_WIDTH-1:0] o_res_data,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_err_zero,
  output logic                  o_err_sync,
  output logic                  o_q_wrt,
  output logic                  o_q_read,
  output logic [DATA_WIDTH-1:0] o_q_data,
  input  logic                  i_q_full,
  input  logic                  i_q_empty,
  input  logic [DATA_WIDTH-1:0] i_q_head
);

  localparam int CW = count_width(QUEUE_SIZE);

  pq_state_e       state_q, state_d;
  pq_op_e          op;
  logic [CW-1:0]   count_q, count_d;
  logic            err_zero_q, err_zero_d;
  logic            err_sync_q, err_sync_d;
  logic            run, res_valid, res_free, res_load;
  logic            push_zero, push_ok, push_acc, push_issue, pop_acc;

  assign run       = (state_q == RUN);
  assign res_free  = !res_valid || i_res_ready;
  assign o_pop_ready = run && !i_q_empty && res_free;
  assign pop_acc   = i_pop_valid && o_pop_ready;

  // Without enqueue support a push can only land on an empty queue or ride a replace.
  assign push_zero    = (i_push_data == '0);
  assign push_ok      = run && (((ENQ_ENA != 0) ? !i_q_full : i_q_empty) || pop_acc);
  assign o_push_ready = push_zero || push_ok;
  assign push_acc     = i_push_valid && o_push_ready;
  assign push_issue   = push_acc && !push_zero;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (i_flush)   state_d = DRAIN;
      DRAIN:   if (i_q_empty) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    op       = OP_NONE;
    res_load = 1'b0;
    case (state_q)
      RUN: begin
        if (push_issue && pop_acc) begin
          op       = OP_REPL;
          res_load = 1'b1;
        end else if (push_issue) begin
          op = (ENQ_ENA != 0) ? OP_ENQ : OP_REPL;
        end else if (pop_acc) begin
          op       = OP_DEQ;
          res_load = 1'b1;
        end
      end
      DRAIN: if (!i_q_empty) op = OP_DEQ;
      default: op = OP_NONE;
    endcase
    o_q_wrt  = (op == OP_ENQ) || (op == OP_REPL);
    o_q_read = (op == OP_DEQ) || (op == OP_REPL);
    o_q_data = o_q_wrt ? i_push_data : '0;
    o_busy   = (state_q == DRAIN);
  end

  // A replace with no accepted pop is the empty-queue insert, so it grows the count.
  always_comb begin
    count_d = count_q;
    if (state_q == DRAIN) begin
      count_d = i_q_empty ? '0 : count_q - CW'(1);
    end else begin
      case (op)
        OP_ENQ:  count_d = count_q + CW'(1);
        OP_DEQ:  count_d = count_q - CW'(1);
        OP_REPL: if (!pop_acc) count_d = count_q + CW'(1);
        default: count_d = count_q;
      endcase
    end
    err_zero_d = err_zero_q || (push_acc && push_zero);
    err_sync_d = err_sync_q
              || ((count_q == CW'(QUEUE_SIZE)) != i_q_full)
              || ((count_q == '0) != i_q_empty);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      count_q    <= '0;
      err_zero_q <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      err_zero_q <= err_zero_d;
      err_sync_q <= err_sync_d;
    end
  end

  assign o_err_zero = err_zero_q;
  assign o_err_sync = err_sync_q;

  pq_res_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_res_reg (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_load  (res_load),
    .i_data  (i_q_head),
    .i_ready (i_res_ready),
    .o_valid (res_valid),
    .o_data  (o_res_data)
  );

  assign o_res_valid = res_valid;

endmodule

// File: tb/tb_pq_host_adapter.sv
// tb/tb_pq_host_adapter.sv - directed scoreboard bench for both ENQ_ENA variants
module tb_pq_host_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid [2];
  logic [15:0] push_data  [2];
  logic        pop_valid  [2];
  logic        res_ready  [2];
  logic        flush      [2];
  logic        push_ready [2];
  logic        pop_ready  [2];
  logic        res_valid  [2];
  logic [15:0] res_data   [2];
  logic        busy       [2];
  logic        err_zero   [2];
  logic        err_sync   [2];
  logic        q_wrt      [2];
  logic        q_read     [2];
  logic [15:0] q_data     [2];
  logic        q_full     [2];
  logic        q_empty    [2];
  logic [15:0] q_head     [2];

  logic [3:0][15:0] qm [2];
  int               qc [2];
  logic [15:0]      exp0 [$];
  logic [15:0]      exp1 [$];
  int               n_assert = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0 supports enqueue, instance 1 is replace-only.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign q_head[g]  = qm[g][0];
    assign q_full[g]  = (qc[g] == 4);
    assign q_empty[g] = (qc[g] == 0);
    pq_host_adapter #(
      .ENQ_ENA   ((g == 0) ? 1 : 0),
      .QUEUE_SIZE(4),
      .DATA_WIDTH(16)
    ) u_dut (
      .i_CLK       (clk),
      .i_RST       (rst),
      .i_push_valid(push_valid[g]),
      .o_push_ready(push_ready[g]),
      .i_push_data (push_data[g]),
      .i_pop_valid (pop_valid[g]),
      .o_pop_ready (pop_ready[g]),
      .o_res_valid (res_valid[g]),
      .i_res_ready (res_ready[g]),
      .o_res_data  (res_data[g]),
      .i_flush     (flush[g]),
      .o_busy      (busy[g]),
      .o_err_zero  (err_zero[g]),
      .o_err_sync  (err_sync[g]),
      .o_q_wrt     (q_wrt[g]),
      .o_q_read    (q_read[g]),
      .o_q_data    (q_data[g]),
      .i_q_full    (q_full[g]),
      .i_q_empty   (q_empty[g]),
      .i_q_head    (q_head[g])
    );
  end

  function automatic logic [3:0][15:0] q_next(input logic [3:0][15:0] a, input int n,
                                              input logic wr, input logic rd, input logic [15:0] d);
    logic [3:0][15:0] r;
    int m;
    r = a;
    m = n;
    if (rd && m > 0) begin
      for (int i = 0; i < 3; i++) r[i] = r[i+1];
      r[3] = '0;
      m--;
    end
    if (wr && m < 4) begin
      r[m] = d;
      for (int i = 3; i > 0; i--)
        if (i <= m && r[i] > r[i-1]) {r[i], r[i-1]} = {r[i-1], r[i]};
    end
    return r;
  endfunction

  function automatic int c_next(input int n, input logic wr, input logic rd);
    int m;
    m = n;
    if (rd && m > 0) m--;
    if (wr && m < 4) m++;
    return m;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        qm[g] <= '0;
        qc[g] <= 0;
      end else begin
        qm[g] <= q_next(qm[g], qc[g], q_wrt[g], q_read[g], q_data[g]);
        qc[g] <= c_next(qc[g], q_wrt[g], q_read[g]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int g, input logic [15:0] d);
    int sz;
    logic [15:0] e;
    sz = (g == 0) ? exp0.size() : exp1.size();
    chk($sformatf("res%0d_expected_pending", g), (sz > 0), 1);
    if (sz > 0) begin
      e = (g == 0) ? exp0.pop_front() : exp1.pop_front();
      chk($sformatf("res%0d_data", g), d, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid[0] && res_ready[0]) sb_pop(0, res_data[0]);
      if (res_valid[1] && res_ready[1]) sb_pop(1, res_data[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push1(input int g, input logic [15:0] v);
    push_valid[g] = 1'b1;
    push_data[g]  = v;
    mid();
    chk("push_ready", push_ready[g], 1);
    chk("push_wrt", q_wrt[g], 1);
    cyc();
    push_valid[g] = 1'b0;
  endtask

  task automatic pop1(input int g, input logic [15:0] e);
    pop_valid[g] = 1'b1;
    if (g == 0) exp0.push_back(e);
    else        exp1.push_back(e);
    mid();
    chk("pop_ready", pop_ready[g], 1);
    chk("pop_read", q_read[g], 1);
    cyc();
    pop_valid[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      push_valid[g] = 1'b0;
      push_data[g]  = '0;
      pop_valid[g]  = 1'b0;
      res_ready[g]  = 1'b1;
      flush[g]      = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mid();
    chk("rst_res_valid", res_valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_err_zero", err_zero[0], 0);
    chk("rst_err_sync", err_sync[0], 0);
    chk("rst_q_wrt", q_wrt[0], 0);
    chk("rst_q_read", q_read[0], 0);
    chk("rst_res_valid1", res_valid[1], 0);
    cyc();

    // Ordered insert then drain by priority.
    push1(0, 16'd5);
    push1(0, 16'd9);
    push1(0, 16'd3);
    pop1(0, 16'd9);
    pop1(0, 16'd5);
    pop1(0, 16'd3);
    mid();
    chk("t1_empty_pop_ready", pop_ready[0], 0);
    chk("t1_err_sync", err_sync[0], 0);
    cyc();

    // Simultaneous push and pop becomes a replace.
    push1(0, 16'd9);
    push1(0, 16'd4);
    push_valid[0] = 1'b1;
    push_data[0]  = 16'd7;
    pop_valid[0]  = 1'b1;
    exp0.push_back(16'd9);
    mid();
    chk("t2_push_ready", push_ready[0], 1);
    chk("t2_pop_ready", pop_ready[0], 1);
    chk("t2_wrt", q_wrt[0], 1);
    chk("t2_read", q_read[0], 1);
    chk("t2_q_data", q_data[0], 7);
    cyc();
    push_valid[0] = 1'b0;
    pop_valid[0]  = 1'b0;
    pop1(0, 16'd7);
    pop1(0, 16'd4);
    mid();
    chk("t2_err_sync", err_sync[0], 0);
    cyc();

    // Full queue: a lone push stalls until a pop pairs with it.
    for (int v = 1; v <= 4; v++) push1(0, 16'(v));
    push_valid[0] = 1'b1;
    push_data[0]  = 16'd8;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("t3_full_push_ready", push_ready[0], 0);
      chk("t3_full_wrt", q_wrt[0], 0);
      cyc();
    end
    pop_valid[0] = 1'b1;
    exp0.push_back(16'd4);
    mid();
    chk("t3_repl_push_ready", push_ready[0], 1);
    chk("t3_repl_wrt", q_wrt[0], 1);
    chk("t3_repl_read", q_read[0], 1);
    cyc();
    push_valid[0] = 1'b0;
    pop_valid[0]  = 1'b0;
    pop1(0, 16'd8);
    pop1(0, 16'd3);
    pop1(0, 16'd2);
    pop1(0, 16'd1);

    // Reserved zero push is swallowed and flagged.
    push_valid[0] = 1'b1;
    push_data[0]  = 16'd0;
    mid();
    chk("t4_zero_ready", push_ready[0], 1);
    chk("t4_zero_wrt", q_wrt[0], 0);
    chk("t4_zero_read", q_read[0], 0);
    chk("t4_err_zero_pre", err_zero[0], 0);
    cyc();
    push_valid[0] = 1'b0;
    mid();
    chk("t4_err_zero_set", err_zero[0], 1);
    cyc();
    cyc();
    mid();
    chk("t4_err_zero_sticky", err_zero[0], 1);
    cyc();

    // Flush with a result held in the output register.
    push1(0, 16'd7);
    push1(0, 16'd6);
    push1(0, 16'd2);
    push1(0, 16'd1);
    res_ready[0] = 1'b0;
    pop_valid[0] = 1'b1;
    exp0.push_back(16'd7);
    mid();
    chk("t5_pop_ready", pop_ready[0], 1);
    cyc();
    pop_valid[0] = 1'b0;
    flush[0]     = 1'b1;
    mid();
    chk("t5_busy_pre", busy[0], 0);
    chk("t5_res_pending", res_valid[0], 1);
    cyc();
    flush[0]     = 1'b0;
    push_data[0] = 16'd5;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t5_drain_busy", busy[0], 1);
      chk("t5_drain_read", q_read[0], 1);
      chk("t5_drain_pop_ready", pop_ready[0], 0);
      chk("t5_drain_push_ready", push_ready[0], 0);
      cyc();
    end
    mid();
    chk("t5_drain_end_busy", busy[0], 1);
    chk("t5_drain_end_read", q_read[0], 0);
    cyc();
    mid();
    chk("t5_run_busy", busy[0], 0);
    chk("t5_res_still_held", res_valid[0], 1);
    chk("t5_err_sync", err_sync[0], 0);
    cyc();
    res_ready[0] = 1'b1;
    push_data[0] = 16'd0;
    cyc();
    mid();
    chk("t5_err_sync_after", err_sync[0], 0);
    cyc();

    // Replace-only variant.
    push_valid[1] = 1'b1;
    push_data[1]  = 16'd4;
    mid();
    chk("t6_empty_push_ready", push_ready[1], 1);
    chk("t6_empty_wrt", q_wrt[1], 1);
    chk("t6_empty_read", q_read[1], 1);
    cyc();
    push_data[1] = 16'd6;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("t6_stall_push_ready", push_ready[1], 0);
      chk("t6_stall_wrt", q_wrt[1], 0);
      cyc();
    end
    pop_valid[1] = 1'b1;
    exp1.push_back(16'd4);
    mid();
    chk("t6_repl_push_ready", push_ready[1], 1);
    chk("t6_repl_wrt", q_wrt[1], 1);
    chk("t6_repl_read", q_read[1], 1);
    cyc();
    push_valid[1] = 1'b0;
    pop_valid[1]  = 1'b0;
    pop1(1, 16'd6);
    mid();
    chk("t6_err_sync", err_sync[1], 0);
    chk("t6_err_zero", err_zero[1], 0);
    cyc();

    for (int i = 0; i < 20 && (exp0.size() + exp1.size()) > 0; i++) cyc();
    chk("sb_drained", exp0.size() + exp1.size(), 0);
    chk("final_err_sync0", err_sync[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
